ps2_keyboard_events: RTL



---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_event_fifo.sv | 38 +++
 rtl/ps2_keyboard_events.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, decoder states and the event record layout
package ps2_pkg;
    localparam logic [7:0] PS2_EXTENDED = 8'hE0;
    localparam logic [7:0] PS2_RELEASED = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam int EV_W = 10;
    typedef enum logic [1:0] {IDLE, PRE_E0, PRE_F0, PRE_E0F0} dec_state_t;
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through event queue with wrap-bit pointers
// Ports: clk/rst_n clock and async active-low reset; push/din write side;
//   pop/dout read side (dout shows the head while !empty); empty/full status.
module ps2_event_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int EV_W       = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [EV_W-1:0] din,
    input  logic            pop,
    output logic [EV_W-1:0] dout,
    output logic            empty,
    output logic            full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [EV_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_push, do_pop;
    assign empty   = wptr == rptr;
    assign full    = wptr == {~rptr[AW], rptr[AW-1:0]};
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a full push still succeeds
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];
    always_ff @(posedge clk)
        if (do_push) mem[wptr[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_keyboard_events.sv
// ps2_keyboard_events: PS/2 keyboard receiver producing queued make/break events and arrow-key state
// Ports: CLK/reset_n board clock and async active-low reset; PS2_CLK/PS2_DATA raw keyboard lines;
//   ev_valid/ev_ready/ev_code/ev_ext/ev_release head-of-queue event handshake;
//   clr_overflow/overflow sticky drop flag; frame_err one-cycle bad frame/timeout pulse;
//   arrows_held {up,down,left,right} live held state.
module ps2_keyboard_events
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 8,
    parameter int FILTER_REPEAT = 1
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       ev_ready,
    input  logic       clr_overflow,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    output logic       frame_err,
    output logic       overflow,
    output logic [3:0] arrows_held
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_TICKS - 1);
    logic [1:0] clk_sync, dat_sync;
    logic [DW-1:0] div_cnt;
    logic tick, clk_prev, fall, frame_ok, rx_valid;
    // holds the last ten received bits; start bit is checked before it shifts out
    logic [9:0] shift;
    logic [7:0] rx_byte;
    logic [3:0] bit_cnt;
    logic [TW-1:0] tmo_cnt;
    dec_state_t state, state_n;
    logic emit, held_valid, held_match, pass;
    ps2_event_t emit_ev, push_ev, head;
    logic [8:0] held_key;
    logic [3:0] arrow_hit;
    logic push, pop, empty, full;
    assign tick     = div_cnt == DIV_MAX;
    assign fall     = tick && clk_prev && !clk_sync[1];
    assign frame_ok = !shift[0] && dat_sync[1] && ^shift[9:1];
    assign rx_byte  = shift[7:0];
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            div_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
        end
    end
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev  <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (tick) clk_prev <= clk_sync[1];
            if (fall) begin
                shift     <= {dat_sync[1], shift[9:1]};
                tmo_cnt   <= '0;
                bit_cnt   <= bit_cnt == 4'd10 ? 4'd0 : bit_cnt + 4'd1;
                rx_valid  <= bit_cnt == 4'd10 && frame_ok;
                frame_err <= bit_cnt == 4'd10 && !frame_ok;
            end else if (tick && bit_cnt != 4'd0) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_MAX) begin
                    bit_cnt   <= '0;
                    tmo_cnt   <= '0;
                    frame_err <= 1'b1;
                end
            end
        end
    end
    always_ff @(posedge CLK or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    // prefix bytes arriving after F0 are ignored; any error drops a pending prefix
    always_comb begin
        state_n      = state;
        emit         = 1'b0;
        emit_ev      = '0;
        emit_ev.code = rx_byte;
        if (frame_err) state_n = IDLE;
        else if (rx_valid) begin
            if (rx_byte == PS2_EXTENDED) state_n = state == IDLE ? PRE_E0 : state;
            else if (rx_byte == PS2_RELEASED)
                state_n = state == IDLE ? PRE_F0 : state == PRE_E0 ? PRE_E0F0 : state;
            else begin
                state_n     = IDLE;
                emit        = 1'b1;
                emit_ev.ext = state == PRE_E0 || state == PRE_E0F0;
                emit_ev.rel = state == PRE_F0 || state == PRE_E0F0;
            end
        end
    end
    assign held_match = held_valid && held_key == {emit_ev.ext, emit_ev.code};
    assign pass       = emit && (emit_ev.rel || FILTER_REPEAT == 0 || !held_match);
    assign arrow_hit  = {4{emit && emit_ev.ext}} &
                        {rx_byte == KEY_UP, rx_byte == KEY_DOWN, rx_byte == KEY_LEFT, rx_byte == KEY_RIGHT};
    assign pop        = ev_valid && ev_ready;
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            push        <= 1'b0;
            push_ev     <= '0;
            held_valid  <= 1'b0;
            held_key    <= '0;
            arrows_held <= '0;
            overflow    <= 1'b0;
        end else begin
            push    <= pass;
            push_ev <= emit_ev;
            if (emit && !emit_ev.rel) begin
                held_valid <= 1'b1;
                held_key   <= {emit_ev.ext, emit_ev.code};
            end else if (emit && held_match) held_valid <= 1'b0;
            arrows_held <= emit_ev.rel ? arrows_held & ~arrow_hit : arrows_held | arrow_hit;
            overflow    <= (push && full && !pop) || (overflow && !clr_overflow);
        end
    end
    ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .EV_W(EV_W)) u_fifo (
        .clk  (CLK),
        .rst_n(reset_n),
        .push (push),
        .din  (push_ev),
        .pop  (pop),
        .dout (head),
        .empty(empty),
        .full (full)
    );
    // head contents are only meaningful while the queue holds an entry
    assign ev_valid   = !empty;
    assign ev_code    = ev_valid ? head.code : 8'h00;
    assign ev_ext     = ev_valid && head.ext;
    assign ev_release = ev_valid && head.rel;
endmodule
